// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  sprite_pkg
//  Shared state encoding, colour width, screen defaults and X-table lookup.
//  Rev 1.0 - initial release
// ============================================================================
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int COLOUR_W         = 3;
    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;
    localparam int MAX_POS          = 16;

    // Tables narrower than MAX_POS entries are zero-extended by the caller.
    function automatic logic [7:0] x_table_entry(input logic [8*MAX_POS-1:0] tbl,
                                                 input int                   slot);
        logic [7:0] entry;
        entry = 8'd0;
        for (int i = 0; i < MAX_POS; i++) begin
            if (i == slot) entry = tbl[8*i +: 8];
        end
        return entry;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_plotter_raster_counter.sv
`default_nettype none
// ============================================================================
//  raster_counter
//  Row-major x/y scan counter with clear, enable and a registered last flag.
//  Rev 1.0 - initial release
// ============================================================================
module raster_counter #(
    parameter  int W  = 9,
    parameter  int H  = 5,
    localparam int XW = (W > 1) ? $clog2(W) : 1,
    localparam int YW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);

    logic w_x_end;
    logic w_y_end;

    assign w_x_end = (o_x == XW'(W - 1));
    assign w_y_end = (o_y == YW'(H - 1));

    // o_last is high for the cycle after the final coordinate was consumed;
    // by then the counters have already wrapped back to (0,0).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            o_x    <= '0;
            o_y    <= '0;
            o_last <= 1'b0;
        end else if (i_clear) begin
            o_x    <= '0;
            o_y    <= '0;
            o_last <= 1'b0;
        end else if (i_enable) begin
            o_last <= w_x_end && w_y_end;
            if (w_x_end) begin
                o_x <= '0;
                o_y <= w_y_end ? '0 : o_y + 1'b1;
            end else begin
                o_x <= o_x + 1'b1;
            end
        end else begin
            o_last <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_plotter.sv
`default_nettype none
// ============================================================================
//  sprite_plotter
//  Sprite rasteriser: one clipped, masked pixel per clock to the VGA adapter.
//  Rev 1.0 - initial release
// ============================================================================
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter  int                            SPRITE_W    = 9,
    parameter  int                            SPRITE_H    = 5,
    parameter  int                            NUM_POS     = 4,
    parameter  logic [8*NUM_POS-1:0]          X_TABLE     = {8'd132, 8'd78, 8'd24, 8'd6},
    parameter  int                            Y_BASE      = 102,
    parameter  logic [SPRITE_W*SPRITE_H-1:0]  SPRITE_MASK = '1,
    parameter  logic [COLOUR_W-1:0]           FG_COLOUR   = 3'b111,
    parameter  logic [COLOUR_W-1:0]           BG_COLOUR   = 3'b000,
    parameter  int                            SCREEN_W    = SCREEN_W_DEFAULT,
    parameter  int                            SCREEN_H    = SCREEN_H_DEFAULT,
    localparam int                            POS_W       = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Erase,
    input  logic [POS_W-1:0]    PosSel,
    output logic [7:0]          XOut,
    output logic [6:0]          YOut,
    output logic [COLOUR_W-1:0] ColourOut,
    output logic                Plot,
    output logic                Busy,
    output logic                DoneDrawing
);

    localparam int c_xw    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int c_yw    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int c_idx_w = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1;
    localparam logic [8*MAX_POS-1:0] c_x_table_ext = (8*MAX_POS)'(X_TABLE);

    state_t            r_state;
    logic [7:0]        r_origin;
    logic              r_erase;

    logic              w_accept;
    logic              w_step;
    logic              w_clear;
    logic [POS_W-1:0]  w_pos;
    logic [7:0]        w_origin;
    logic              w_erase;
    logic [c_xw-1:0]   w_x;
    logic [c_yw-1:0]   w_y;
    logic              w_last;
    logic [c_idx_w-1:0] w_idx;
    logic [8:0]        w_sx;
    logic [8:0]        w_sy;
    logic              w_plot;

    assign w_accept = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // The counters rest at (0,0) outside DRAW, so the accepting edge already
    // renders pixel (0,0) and steps the counter; this gives the one-cycle
    // Start-to-first-pixel latency.
    assign w_step  = w_accept || ((r_state == ST_DRAW) && !w_last);
    assign w_clear = !w_step && (r_state != ST_DRAW);

    always_comb begin
        w_pos = PosSel;
        if (int'(PosSel) >= NUM_POS) w_pos = POS_W'(NUM_POS - 1);
    end

    assign w_origin = w_accept ? x_table_entry(c_x_table_ext, int'(w_pos)) : r_origin;
    assign w_erase  = w_accept ? Erase : r_erase;

    raster_counter #(
        .W (SPRITE_W),
        .H (SPRITE_H)
    ) u_raster (
        .Clock    (Clock),
        .Reset    (Reset),
        .i_clear  (w_clear),
        .i_enable (w_step),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_last   (w_last)
    );

    assign w_idx  = c_idx_w'(w_y) * c_idx_w'(SPRITE_W) + c_idx_w'(w_x);
    assign w_sx   = {1'b0, w_origin} + 9'(w_x);
    assign w_sy   = 9'(Y_BASE) + 9'(w_y);
    assign w_plot = (w_sx < 9'(SCREEN_W)) && (w_sy < 9'(SCREEN_H)) &&
                    (w_erase || SPRITE_MASK[w_idx]);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_origin    <= 8'd0;
            r_erase     <= 1'b0;
            XOut        <= 8'd0;
            YOut        <= 7'd0;
            ColourOut   <= '0;
            Plot        <= 1'b0;
            Busy        <= 1'b0;
            DoneDrawing <= 1'b0;
        end else if (w_accept) begin
            r_state     <= ST_DRAW;
            r_origin    <= w_origin;
            r_erase     <= Erase;
            XOut        <= w_sx[7:0];
            YOut        <= w_sy[6:0];
            ColourOut   <= w_erase ? BG_COLOUR : FG_COLOUR;
            Plot        <= w_plot;
            Busy        <= 1'b1;
            DoneDrawing <= 1'b0;
        end else begin
            case (r_state)
                ST_DRAW: begin
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        Plot        <= 1'b0;
                        Busy        <= 1'b0;
                        DoneDrawing <= 1'b1;
                    end else begin
                        XOut      <= w_sx[7:0];
                        YOut      <= w_sy[6:0];
                        ColourOut <= w_erase ? BG_COLOUR : FG_COLOUR;
                        Plot      <= w_plot;
                        Busy      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    Plot        <= 1'b0;
                    Busy        <= 1'b0;
                    DoneDrawing <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    Plot        <= 1'b0;
                    Busy        <= 1'b0;
                    DoneDrawing <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
